alu_seq: RTL

Parametrised, registered ALU for the execute stage: the next generation of the stage's 16-bit ALU. Adds a data-width parameter, a valid/ready handshake, and a persistent flag register with a restore port for RETI. Also adds multi-cycle iterative shift and multiply units that stall issue while busy. It sits between decode/register-read and the memory stage and owns the architectural CCR.

---
 rtl/alu_if.sv | 22 ++
 rtl/alu_seq.sv | 137 +++++++++++++
 2 files changed

// File: rtl/alu_if.sv
// alu_if: issue/response bundle between the execute-stage ALU and its neighbours
interface alu_if #(parameter int W = 16) ();
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   alu_control;
  logic [W-1:0] src;
  logic [W-1:0] dst;
  logic         flags_we;
  logic [3:0]   flags_in;
  logic [W-1:0] result;
  logic         out_valid;
  logic [3:0]   flags;
  logic         busy;
  modport master (
    output in_valid, alu_control, src, dst, flags_we, flags_in,
    input  in_ready, result, out_valid, flags, busy
  );
  modport slave (
    input  in_valid, alu_control, src, dst, flags_we, flags_in,
    output in_ready, result, out_valid, flags, busy
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered execute-stage ALU owning the CCR, with iterative shift/multiply.
// Ports: clk, rst (sync active-high); bus (alu_if.slave): in_valid/in_ready issue
// handshake, alu_control/src/dst operands, flags_we/flags_in CCR restore,
// result/out_valid/flags response, busy while a multi-cycle op runs.
module alu_seq #(
  parameter int W   = 16,
  parameter int SHW = $clog2(W + 1)
) (
  input logic clk,
  input logic rst,
  alu_if.slave bus
);
  localparam int CW = $clog2(W + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;
  state_t       state_q;
  logic [W-1:0] result_q, mc_q, hi_q, lo_q, r, sh_lo, mul_hi, mul_lo;
  logic [W:0]   sum, mac;
  logic [3:0]   flags_q, f_new;
  logic [CW-1:0] cnt_q;
  logic [31:0]  amt;
  logic [4:0]   op;
  logic         out_valid_q, dir_q, acc, c, v, wr, wzn, sh_out, is_sh;
  assign op            = bus.alu_control;
  assign bus.in_ready  = (state_q == IDLE) & ~rst;
  assign bus.busy      = state_q != IDLE;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
  assign bus.out_valid = out_valid_q;
  assign acc           = bus.in_valid & bus.in_ready;
  assign is_sh         = (op == 5'd13) || (op == 5'd14);
  assign amt = 32'(bus.dst[SHW-1:0]) > 32'(W) ? 32'(W) : 32'(bus.dst[SHW-1:0]);
  // Single-cycle datapath; a zero-length shift also completes here with result = src.
  always_comb begin
    sum = '0;
    r   = bus.src;
    c   = flags_q[0];
    v   = flags_q[3];
    wr  = 1'b0;
    wzn = 1'b0;
    case (op)
      5'd1: c = 1'b1;
      5'd2: c = 1'b0;
      5'd3: begin r = ~bus.dst; wr = 1'b1; wzn = 1'b1; end
      5'd4: begin
        r = bus.dst + W'(1); wr = 1'b1; wzn = 1'b1;
        v = bus.dst == {1'b0, {(W-1){1'b1}}};
      end
      5'd5: begin
        r = bus.dst - W'(1); wr = 1'b1; wzn = 1'b1;
        v = bus.dst == {1'b1, {(W-1){1'b0}}};
      end
      5'd8, 5'd15, 5'd16, 5'd17: wr = 1'b1;
      5'd9, 5'd27: begin
        sum = {1'b0, bus.src} + {1'b0, bus.dst} + {{W{1'b0}}, (op == 5'd27) & flags_q[0]};
        r = sum[W-1:0]; c = sum[W]; wr = 1'b1; wzn = 1'b1;
        v = (bus.src[W-1] == bus.dst[W-1]) & (r[W-1] != bus.src[W-1]);
      end
      // Bit W of the W+1-bit difference is the borrow.
      5'd10, 5'd28: begin
        sum = {1'b0, bus.src} - {1'b0, bus.dst} - {{W{1'b0}}, (op == 5'd28) & flags_q[0]};
        r = sum[W-1:0]; c = sum[W]; wr = 1'b1; wzn = 1'b1;
        v = (bus.src[W-1] != bus.dst[W-1]) & (r[W-1] == bus.dst[W-1]);
      end
      5'd11: begin r = bus.src & bus.dst; wr = 1'b1; wzn = 1'b1; end
      5'd12: begin r = bus.src | bus.dst; wr = 1'b1; wzn = 1'b1; end
      5'd30: begin r = bus.src ^ bus.dst; wr = 1'b1; wzn = 1'b1; end
      5'd13, 5'd14: begin wr = 1'b1; wzn = 1'b1; end
      default: ;
    endcase
    f_new = {v, wzn ? r[W-1] : flags_q[2], wzn ? (r == '0) : flags_q[1], c};
  end
  assign sh_lo  = dir_q ? {lo_q[W-2:0], 1'b0} : {1'b0, lo_q[W-1:1]};
  assign sh_out = dir_q ? lo_q[W-1] : lo_q[0];
  // Shift-add step: {hi,lo} holds partial product and remaining multiplier bits.
  assign mac    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mc_q} : '0);
  assign mul_hi = mac[W:1];
  assign mul_lo = {mac[0], lo_q[W-1:1]};
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      mc_q        <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      dir_q       <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (acc) begin
          if (op == 5'd29) begin
            state_q <= MUL;
            cnt_q   <= CW'(W);
            mc_q    <= bus.src;
            hi_q    <= '0;
            lo_q    <= bus.dst;
          end else if (is_sh && amt != 0) begin
            state_q <= SHIFT;
            cnt_q   <= CW'(amt);
            lo_q    <= bus.src;
            dir_q   <= op == 5'd13;
          end else begin
            out_valid_q <= 1'b1;
            flags_q     <= f_new;
            if (wr) result_q <= r;
          end
        end
        SHIFT: begin
          lo_q  <= sh_lo;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b1;
            result_q    <= sh_lo;
            flags_q     <= {flags_q[3], sh_lo[W-1], sh_lo == '0, sh_out};
          end
        end
        MUL: begin
          hi_q  <= mul_hi;
          lo_q  <= mul_lo;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b1;
            result_q    <= mul_lo;
            flags_q     <= {flags_q[3], mul_lo[W-1], mul_lo == '0, mul_hi != '0};
          end
        end
        default: state_q <= IDLE;
      endcase
      // Restore has priority over any op flag write on the same edge.
      if (bus.flags_we) flags_q <= bus.flags_in;
    end
  end
endmodule
